// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key two-flop synchronizer, debounce FSM, and
// registered press/release pulses plus a saturating long-hold flag.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NUM_KEYS-1:0] i_keyN,
  output logic [NUM_KEYS-1:0] o_keyLevel,
  output logic [NUM_KEYS-1:0] o_keyPress,
  output logic [NUM_KEYS-1:0] o_keyRelease,
  output logic [NUM_KEYS-1:0] o_keyHold
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int H_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [H_W-1:0]  H_MAX   = H_W'(HOLD_CYCLES);
  localparam logic [H_W-1:0]  H_ONE   = H_W'(1);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_e;

  key_state_e          r_state   [NUM_KEYS];
  logic [DB_W-1:0]     r_dbCnt   [NUM_KEYS];
  logic [H_W-1:0]      r_hCnt    [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic [NUM_KEYS-1:0] r_hold;

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_mismatch;
  logic [NUM_KEYS-1:0] w_accept;

  // Synchronizer, inverted so that 1 means pressed.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~i_keyN;
      r_sync2 <= r_sync1;
    end
  end

  // A change is accepted on the edge that sees the last required mismatch.
  always_comb begin
    w_level    = '0;
    w_mismatch = '0;
    w_accept   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_level[k]    = (r_state[k] == PRESSED);
      w_mismatch[k] = (r_sync2[k] != w_level[k]);
      w_accept[k]   = w_mismatch[k] && (r_dbCnt[k] == DB_LAST);
    end
  end

  // Per-key debounce FSM with pulse and hold registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_press   <= '0;
      r_release <= '0;
      r_hold    <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_state[k] <= RELEASED;
        r_dbCnt[k] <= '0;
        r_hCnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (!w_mismatch[k] || w_accept[k]) begin
          r_dbCnt[k] <= '0;
        end else begin
          r_dbCnt[k] <= r_dbCnt[k] + DB_ONE;
        end

        case (r_state[k])
          RELEASED: begin
            r_hCnt[k]    <= '0;
            r_hold[k]    <= 1'b0;
            r_release[k] <= 1'b0;
            if (w_accept[k]) begin
              r_state[k] <= PRESSED;
              r_press[k] <= 1'b1;
            end else begin
              r_state[k] <= RELEASED;
              r_press[k] <= 1'b0;
            end
          end
          PRESSED: begin
            r_press[k] <= 1'b0;
            if (w_accept[k]) begin
              r_state[k]   <= RELEASED;
              r_release[k] <= 1'b1;
              r_hCnt[k]    <= '0;
              r_hold[k]    <= 1'b0;
            end else begin
              r_state[k]   <= PRESSED;
              r_release[k] <= 1'b0;
              // Hold flag lags the counter by one edge, so it rises HOLD_CYCLES+1 edges in.
              r_hold[k]    <= (r_hCnt[k] == H_MAX);
              if (r_hCnt[k] != H_MAX) begin
                r_hCnt[k] <= r_hCnt[k] + H_ONE;
              end else begin
                r_hCnt[k] <= H_MAX;
              end
            end
          end
          default: begin
            r_state[k]   <= RELEASED;
            r_press[k]   <= 1'b0;
            r_release[k] <= 1'b0;
            r_hCnt[k]    <= '0;
            r_hold[k]    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_keyLevel   = w_level;
  assign o_keyPress   = r_press;
  assign o_keyRelease = r_release;
  assign o_keyHold    = r_hold;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: per-cycle scoreboard against a sample-history model,
// hand-written corner sequences with fixed expectations, and a vector table.
module tb_key_conditioner;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int HC = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NK-1:0] keyN;
  logic [NK-1:0] level, press, rel, hold;

  key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_keyN(keyN),
    .o_keyLevel(level), .o_keyPress(press), .o_keyRelease(rel), .o_keyHold(hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] hold;
  } exp_t;

  typedef struct {
    logic [NK-1:0] keyN;
    int            cycles;
    logic [NK-1:0] exp_level;
  } vec_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [NK-1:0] m_s1, m_s2, m_level;
  logic [DB-1:0] m_hist [NK];
  int            m_ped  [NK];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_level = '0;
    for (int k = 0; k < NK; k++) begin
      m_hist[k] = '0;
      m_ped[k] = 0;
    end
  endfunction

  // A key flips once its last DB synchronized samples all disagree with its level.
  function automatic exp_t model_edge(input logic [NK-1:0] kn);
    exp_t e;
    logic [NK-1:0] obs;
    obs = m_s2;
    m_s2 = m_s1;
    m_s1 = ~kn;
    e = '0;
    for (int k = 0; k < NK; k++) begin
      m_hist[k] = {m_hist[k][DB-2:0], obs[k]};
      if (m_hist[k] == {DB{~m_level[k]}}) begin
        m_level[k] = ~m_level[k];
        if (m_level[k]) begin
          e.press[k] = 1'b1;
          m_ped[k] = 0;
        end else begin
          e.rel[k] = 1'b1;
        end
      end else if (m_level[k] && m_ped[k] < HC + 1) begin
        m_ped[k]++;
      end
      e.hold[k] = m_level[k] && (m_ped[k] >= HC + 1);
    end
    e.level = m_level;
    return e;
  endfunction

  task automatic tick(input logic [NK-1:0] kn);
    exp_t e;
    keyN = kn;
    sb_q.push_back(model_edge(kn));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb", {level, press, rel, hold}, e);
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    model_reset();
    #1;
    check("reset_async", {level, press, rel, hold}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {level, press, rel, hold}, 16'h0000);
    rstn = 1'b1;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'b1111, 8,  4'b0000};
    vecs[1] = '{4'b0000, 3,  4'b0000};
    vecs[2] = '{4'b1111, 5,  4'b0000};
    vecs[3] = '{4'b1010, 6,  4'b0101};
    vecs[4] = '{4'b1010, 14, 4'b0101};
    vecs[5] = '{4'b0101, 6,  4'b1010};
    vecs[6] = '{4'b1111, 6,  4'b0000};
    vecs[7] = '{4'b1110, 4,  4'b0000};
    vecs[8] = '{4'b1111, 2,  4'b0001};

    rstn = 1'b1;
    keyN = 4'b0000;
    model_reset();
    #1;
    // Reset with all keys held, then release reset: all keys qualify together.
    reset_dut();
    repeat (5) tick(4'b0000);
    check("rst_rel_nopulse", {12'h000, press}, 16'h0000);
    tick(4'b0000);
    check("rst_rel_press", {8'h00, press, level}, {8'h00, 4'b1111, 4'b1111});
    tick(4'b0000);
    check("rst_rel_pulse1", {8'h00, press, level}, {8'h00, 4'b0000, 4'b1111});
    repeat (5) tick(4'b1111);
    tick(4'b1111);
    check("all_release", {8'h00, rel, level}, {8'h00, 4'b1111, 4'b0000});
    repeat (3) tick(4'b1111);

    // Clean press/release on key 1.
    repeat (5) tick(4'b1101);
    check("k1_nopulse", {12'h000, press}, 16'h0000);
    tick(4'b1101);
    check("k1_press", {8'h00, press, level}, {8'h00, 4'b0010, 4'b0010});
    tick(4'b1101);
    check("k1_press_end", {12'h000, press}, 16'h0000);
    repeat (2) tick(4'b1101);
    repeat (5) tick(4'b1111);
    check("k1_norel", {8'h00, rel, level}, {8'h00, 4'b0000, 4'b0010});
    tick(4'b1111);
    check("k1_release", {8'h00, rel, level}, {8'h00, 4'b0010, 4'b0000});
    repeat (3) tick(4'b1111);

    // Bounce on key 0: 3 low, 1 high, then steady low.
    repeat (3) tick(4'b1110);
    tick(4'b1111);
    repeat (5) tick(4'b1110);
    check("bounce_nopulse", {12'h000, press}, 16'h0000);
    tick(4'b1110);
    check("bounce_press", {12'h000, press}, {12'h000, 4'b0001});
    repeat (6) tick(4'b1111);
    repeat (3) tick(4'b1111);

    // Hold on key 2.
    repeat (6) tick(4'b1011);
    check("hold_level", {12'h000, level}, {12'h000, 4'b0100});
    repeat (10) tick(4'b1011);
    check("hold_early", {12'h000, hold}, 16'h0000);
    tick(4'b1011);
    check("hold_rise", {12'h000, hold}, {12'h000, 4'b0100});
    repeat (3) tick(4'b1011);
    repeat (5) tick(4'b1111);
    check("hold_keep", {8'h00, hold, level}, {8'h00, 4'b0100, 4'b0100});
    tick(4'b1111);
    check("hold_clear", {4'h0, rel, hold, level}, {4'h0, 4'b0100, 4'b0000, 4'b0000});
    repeat (3) tick(4'b1111);

    // Keys 0 and 3 together.
    repeat (5) tick(4'b0110);
    tick(4'b0110);
    check("simul_press", {8'h00, press, level}, {8'h00, 4'b1001, 4'b1001});
    repeat (6) tick(4'b1111);
    check("simul_rel", {12'h000, level}, 16'h0000);
    repeat (3) tick(4'b1111);

    // Reset while key 0 is mid-qualification (count at 2).
    repeat (4) tick(4'b1110);
    reset_dut();
    repeat (5) tick(4'b1110);
    check("midrst_nopulse", {12'h000, press}, 16'h0000);
    tick(4'b1110);
    check("midrst_press", {12'h000, press}, {12'h000, 4'b0001});
    repeat (9) tick(4'b1111);

    // Vector table.
    for (int v = 0; v < 9; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) tick(vecs[v].keyN);
      check("vec_level", {12'h000, level}, {12'h000, vecs[v].exp_level});
    end

    // Random runs, checked by the scoreboard alone.
    for (int i = 0; i < 60; i++) begin
      logic [NK-1:0] kn;
      int            len;
      kn = NK'($urandom);
      len = int'($urandom_range(1, 9));
      for (int c = 0; c < len; c++) tick(kn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
